// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: E/M forwarding, load-use and cache stall/flush control, a per-register
// pending-write scoreboard for multi-cycle units, and a round-robin arbiter for their write-back port.
module hazard_scoreboard #(
    parameter int AW     = 4,
    parameter int NUNITS = 2,
    parameter int CNTW   = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [AW-1:0]        RA1D,
    input  logic [AW-1:0]        RA2D,
    input  logic [AW-1:0]        WA3D,
    input  logic                 RegWriteD,
    input  logic [AW-1:0]        RA1E,
    input  logic [AW-1:0]        RA2E,
    input  logic [AW-1:0]        RA2M,
    input  logic [AW-1:0]        WA3E,
    input  logic [AW-1:0]        WA3M,
    input  logic [AW-1:0]        WA3W,
    input  logic                 RegWriteE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 MemtoRegE,
    input  logic                 MemtoRegW,
    input  logic                 MemWriteM,
    input  logic                 PCSrcE,
    input  logic                 CacheStall,
    input  logic [NUNITS-1:0]    IssueD,
    input  logic [NUNITS-1:0]    IssueE,
    input  logic [NUNITS-1:0]    UnitDone,
    input  logic [NUNITS*AW-1:0] UnitWA,
    output logic [NUNITS-1:0]    UnitGrant,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 ForwardM,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 StallW,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic [2**AW-1:0]     Pending,
    output logic [NUNITS-1:0]    UnitBusy,
    output logic [CNTW-1:0]      StallCount
);
    localparam int NREG = 2**AW;
    localparam int PW   = (NUNITS > 1) ? $clog2(NUNITS) : 1;

    logic [NREG-1:0]   pend_q, pend_d;
    logic [NUNITS-1:0] busy_q, busy_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic [NUNITS-1:0] req, grant, acc;
    logic [PW-1:0]     cand, gidx;
    logic              found;
    logic              ldrstall, sbstall, dstall;

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RA1E == WA3M))      ForwardAE = 2'b10;
        else if (RegWriteW && (RA1E == WA3W)) ForwardAE = 2'b01;
        ForwardBE = 2'b00;
        if (RegWriteM && (RA2E == WA3M))      ForwardBE = 2'b10;
        else if (RegWriteW && (RA2E == WA3W)) ForwardBE = 2'b01;
        ForwardM = (RA2M == WA3W) && MemWriteM && MemtoRegW && RegWriteW;
    end

    // A unit is also unavailable to D when the E-stage op is about to claim it this cycle.
    always_comb begin
        ldrstall = MemtoRegE && RegWriteE && ((RA1D == WA3E) || (RA2D == WA3E));
        sbstall  = pend_q[RA1D] || pend_q[RA2D] || (RegWriteD && pend_q[WA3D])
                   || (|(IssueD & busy_q)) || (|(IssueD & IssueE));
        dstall   = ldrstall || sbstall;
        StallF   = dstall || CacheStall;
        StallD   = dstall || CacheStall;
        StallE   = CacheStall;
        StallM   = CacheStall;
        StallW   = CacheStall;
        FlushD   = PCSrcE;
        FlushE   = (dstall || PCSrcE) && !CacheStall;
    end

    // UnitDone/UnitGrant handshake: a unit raises UnitDone with UnitWA stable and holds both
    // until it sees UnitGrant high; the result transfers on the rising edge where UnitGrant is high.
    always_comb begin
        req   = UnitDone & busy_q;
        grant = '0;
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NUNITS; i++) begin
            cand = PW'((int'(rr_q) + i) % NUNITS);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                gidx        = cand;
            end
        end
        rr_d = found ? PW'((int'(gidx) + 1) % NUNITS) : rr_q;
    end

    assign UnitGrant = grant;
    assign acc       = CacheStall ? '0 : IssueE;

    // Clears are applied before sets so a same-cycle re-issue keeps the bit/unit marked.
    always_comb begin
        pend_d = pend_q;
        for (int u = 0; u < NUNITS; u++) begin
            if (grant[u]) pend_d[UnitWA[u*AW +: AW]] = 1'b0;
        end
        for (int u = 0; u < NUNITS; u++) begin
            if (acc[u]) pend_d[WA3E] = 1'b1;
        end
        busy_d = (busy_q & ~grant) | acc;
        cnt_d  = (StallD && (cnt_q != {CNTW{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend_q <= '0;
            busy_q <= '0;
            rr_q   <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            busy_q <= busy_d;
            rr_q   <= rr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign Pending    = pend_q;
    assign UnitBusy   = busy_q;
    assign StallCount = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a behavioural hazard-unit model.
module tb_hazard_scoreboard;
    logic       CLK, RESET;
    logic [3:0] RA1D, RA2D, WA3D, RA1E, RA2E, RA2M, WA3E, WA3M, WA3W;
    logic       RegWriteD, RegWriteE, RegWriteM, RegWriteW;
    logic       MemtoRegE, MemtoRegW, MemWriteM, PCSrcE, CacheStall;
    logic [1:0] IssueD, IssueE, UnitDone, UnitGrant, UnitGrant2, ForwardAE, ForwardBE;
    logic [1:0] ForwardAE2, ForwardBE2, UnitBusy, UnitBusy2;
    logic [7:0] UnitWA;
    logic       ForwardM, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
    logic       ForwardM2, StallF2, StallD2, StallE2, StallM2, StallW2, FlushD2, FlushE2;
    logic [15:0] Pending, Pending2, StallCount;
    logic [1:0]  StallCount2;

    hazard_scoreboard #(.AW(4), .NUNITS(2), .CNTW(16)) dut (
        .CLK(CLK), .RESET(RESET), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D), .RegWriteD(RegWriteD),
        .RA1E(RA1E), .RA2E(RA2E), .RA2M(RA2M), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegW(MemtoRegW), .MemWriteM(MemWriteM), .PCSrcE(PCSrcE),
        .CacheStall(CacheStall), .IssueD(IssueD), .IssueE(IssueE), .UnitDone(UnitDone),
        .UnitWA(UnitWA), .UnitGrant(UnitGrant), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardM(ForwardM), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE), .Pending(Pending),
        .UnitBusy(UnitBusy), .StallCount(StallCount)
    );

    hazard_scoreboard #(.AW(4), .NUNITS(2), .CNTW(2)) dut2 (
        .CLK(CLK), .RESET(RESET), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D), .RegWriteD(RegWriteD),
        .RA1E(RA1E), .RA2E(RA2E), .RA2M(RA2M), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegW(MemtoRegW), .MemWriteM(MemWriteM), .PCSrcE(PCSrcE),
        .CacheStall(CacheStall), .IssueD(IssueD), .IssueE(IssueE), .UnitDone(UnitDone),
        .UnitWA(UnitWA), .UnitGrant(UnitGrant2), .ForwardAE(ForwardAE2), .ForwardBE(ForwardBE2),
        .ForwardM(ForwardM2), .StallF(StallF2), .StallD(StallD2), .StallE(StallE2),
        .StallM(StallM2), .StallW(StallW2), .FlushD(FlushD2), .FlushE(FlushE2),
        .Pending(Pending2), .UnitBusy(UnitBusy2), .StallCount(StallCount2)
    );

    // clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // behavioural model state
    bit m_pend[16];
    bit m_busy[2];
    int m_ptr, m_cnt, m_cnt2;

    logic [1:0]  e_fae, e_fbe, e_grant;
    logic        e_fm, e_dstall, e_stalld;
    logic [6:0]  e_ctrl;
    logic [15:0] e_pend;
    logic [1:0]  e_busy;
    int          e_gidx;

    task automatic model_reset();
        foreach (m_pend[r]) m_pend[r] = 0;
        foreach (m_busy[u]) m_busy[u] = 0;
        m_ptr = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic exp_comb();
        bit ldr, sb;
        int u;
        e_fae = (RegWriteM && RA1E == WA3M) ? 2'b10 : (RegWriteW && RA1E == WA3W) ? 2'b01 : 2'b00;
        e_fbe = (RegWriteM && RA2E == WA3M) ? 2'b10 : (RegWriteW && RA2E == WA3W) ? 2'b01 : 2'b00;
        e_fm  = (RA2M == WA3W) && MemWriteM && MemtoRegW && RegWriteW;
        ldr   = MemtoRegE && RegWriteE && (RA1D == WA3E || RA2D == WA3E);
        sb    = m_pend[RA1D] || m_pend[RA2D] || (RegWriteD && m_pend[WA3D]);
        for (int k = 0; k < 2; k++)
            if (IssueD[k] && (m_busy[k] || IssueE[k])) sb = 1;
        e_dstall = ldr || sb;
        e_stalld = e_dstall || CacheStall;
        e_ctrl = {e_stalld, e_stalld, CacheStall, CacheStall, CacheStall, PCSrcE,
                  (e_dstall || PCSrcE) && !CacheStall};
        e_gidx = -1;
        for (int k = 0; k < 2; k++) begin
            u = (m_ptr + k) % 2;
            if (e_gidx < 0 && UnitDone[u] && m_busy[u]) e_gidx = u;
        end
        e_grant = 2'b00;
        if (e_gidx >= 0) e_grant[e_gidx] = 1'b1;
        for (int r = 0; r < 16; r++) e_pend[r] = m_pend[r];
        for (int k = 0; k < 2; k++) e_busy[k] = m_busy[k];
    endtask

    // check all outputs mid-cycle against the model
    task automatic settle();
        @(negedge CLK);
        exp_comb();
        check_eq("ForwardAE", ForwardAE, e_fae);
        check_eq("ForwardBE", ForwardBE, e_fbe);
        check_eq("ForwardM", ForwardM, e_fm);
        check_eq("stall_flush", {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}, e_ctrl);
        check_eq("UnitGrant", UnitGrant, e_grant);
        check_eq("Pending", Pending, e_pend);
        check_eq("UnitBusy", UnitBusy, e_busy);
        check_eq("StallCount", StallCount, m_cnt);
        check_eq("StallCount_w2", StallCount2, m_cnt2);
    endtask

    // advance one clock edge and apply the same edge to the model
    task automatic tick();
        @(posedge CLK);
        exp_comb();
        if (e_gidx >= 0) begin
            m_busy[e_gidx] = 0;
            m_pend[UnitWA[e_gidx*4 +: 4]] = 0;
            m_ptr = (e_gidx + 1) % 2;
        end
        if (!CacheStall) begin
            for (int k = 0; k < 2; k++)
                if (IssueE[k]) begin
                    m_busy[k] = 1;
                    m_pend[WA3E] = 1;
                end
        end
        if (e_stalld) begin
            m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
        #1;
    endtask

    task automatic clear_inputs();
        {RA1D, RA2D, WA3D, RA1E, RA2E, RA2M, WA3E, WA3M, WA3W} = '0;
        {RegWriteD, RegWriteE, RegWriteM, RegWriteW} = '0;
        {MemtoRegE, MemtoRegW, MemWriteM, PCSrcE, CacheStall} = '0;
        IssueD = '0; IssueE = '0; UnitDone = '0; UnitWA = '0;
    endtask

    task automatic random_inputs();
        int sel;
        RA1D = 4'($urandom_range(0, 7)); RA2D = 4'($urandom_range(0, 7));
        WA3D = 4'($urandom_range(0, 7)); RA1E = 4'($urandom_range(0, 7));
        RA2E = 4'($urandom_range(0, 7)); RA2M = 4'($urandom_range(0, 7));
        WA3E = 4'($urandom_range(0, 7)); WA3M = 4'($urandom_range(0, 7));
        WA3W = 4'($urandom_range(0, 7));
        {RegWriteD, RegWriteE, RegWriteM, RegWriteW} = 4'($urandom);
        {MemtoRegE, MemtoRegW, MemWriteM} = 3'($urandom);
        PCSrcE     = ($urandom_range(0, 5) == 0);
        CacheStall = ($urandom_range(0, 7) == 0);
        sel = $urandom_range(0, 5);
        IssueE = (sel == 0) ? 2'b01 : (sel == 1) ? 2'b10 : 2'b00;
        sel = $urandom_range(0, 5);
        IssueD = (sel == 0) ? 2'b01 : (sel == 1) ? 2'b10 : 2'b00;
        UnitDone = 2'($urandom);
        UnitWA   = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
    endtask

    // asynchronous reset pulse between the falling and next rising edge
    task automatic mid_reset();
        #2 RESET = 1'b1;
        #1;
        check_eq("rst_Pending", Pending, 0);
        check_eq("rst_UnitBusy", UnitBusy, 0);
        check_eq("rst_UnitGrant", UnitGrant, 0);
        check_eq("rst_StallCount", StallCount, 0);
        check_eq("rst_StallCount_w2", StallCount2, 0);
        model_reset();
        #1 RESET = 1'b0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        check_eq("init_Pending", Pending, 0);
        check_eq("init_UnitBusy", UnitBusy, 0);
        check_eq("init_StallCount", StallCount, 0);
        #2 RESET = 1'b0;
        tick();

        // scoreboard set, D-stage stall, then two-unit round-robin drain
        IssueE = 2'b01; WA3E = 4'd5;
        settle(); tick();
        clear_inputs(); RA1D = 4'd5;
        settle();
        check_eq("sb_pend5", Pending, 16'h0020);
        check_eq("sb_stalld", StallD, 1);
        check_eq("sb_flushe", FlushE, 1);
        tick();
        clear_inputs(); IssueE = 2'b10; WA3E = 4'd6;
        settle(); tick();
        clear_inputs(); RA1D = 4'd5; UnitDone = 2'b11; UnitWA = {4'd6, 4'd5};
        settle();
        check_eq("arb_first", UnitGrant, 2'b01);
        check_eq("arb_stall_held", StallD, 1);
        tick();
        settle();
        check_eq("arb_second", UnitGrant, 2'b10);
        check_eq("arb_stall_released", StallD, 0);
        tick();
        clear_inputs();
        settle();
        check_eq("arb_drained", {Pending, 14'd0, UnitBusy}, 0);
        tick();

        // forwarding priority
        RA1E = 4'd3; WA3M = 4'd3; WA3W = 4'd3; RegWriteM = 1; RegWriteW = 1;
        settle();
        check_eq("fwd_m_prio", ForwardAE, 2'b10);
        tick();
        RegWriteM = 0;
        settle();
        check_eq("fwd_w", ForwardAE, 2'b01);
        tick();

        // load-use together with cache stall
        clear_inputs();
        MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd2; RA2D = 4'd2; CacheStall = 1;
        settle();
        check_eq("ldr_cache", {StallF, StallD, StallE, StallM, StallW, FlushE}, 6'b111110);
        tick();

        // reset while a unit op is outstanding
        clear_inputs(); IssueE = 2'b01; WA3E = 4'd4;
        settle(); tick();
        clear_inputs();
        settle();
        check_eq("pre_rst_pend", Pending, 16'h0010);
        check_eq("pre_rst_busy", UnitBusy, 2'b01);
        mid_reset();
        tick();

        // saturating counter on the narrow instance
        clear_inputs(); CacheStall = 1;
        for (int i = 1; i <= 5; i++) begin
            settle(); tick();
            check_eq("cnt_w2", StallCount2, (i < 3) ? i : 3);
            check_eq("cnt_w16", StallCount, i);
        end

        // randomized traffic
        for (int n = 0; n < 2500; n++) begin
            random_inputs();
            settle();
            if ($urandom_range(0, 199) == 0) mid_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
